// File: rtl/fir_output_capture.sv
// Captures a scaled, saturated window of FIR output samples into a readback buffer.
// An arm pulse starts a run that skips a programmable number of samples, then stores a programmable count.
module fir_output_capture #(
    parameter int unsigned IN_WIDTH   = 38,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned DEPTH      = 5500,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   y_in,
    input  logic                  y_valid,
    input  logic                  arm,
    input  logic [4:0]            shift,
    input  logic [15:0]           skip,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [OUT_WIDTH-1:0]  rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           sat_count
);

    localparam int unsigned SW        = IN_WIDTH + 1;
    localparam int unsigned MAX_SHIFT = 22;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [OUT_WIDTH-1:0]  OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]  OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state_q, state_nx;

    logic [4:0]            shift_q;
    logic [15:0]           skip_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [15:0]           skip_cnt_q;
    logic [ADDR_WIDTH-1:0] wptr_q;

    logic start_c, skip_inc_c, wr_en_c;

    logic [4:0]           sh_c;
    logic signed [SW-1:0] ext_c, rnd_c, sum_c, shd_c;
    logic                 sat_c;
    logic [OUT_WIDTH-1:0] scaled_c;

    logic [OUT_WIDTH-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_nx;
    end

    // Next-state and datapath enables
    always_comb begin
        state_nx   = state_q;
        start_c    = 1'b0;
        skip_inc_c = 1'b0;
        wr_en_c    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    start_c  = 1'b1;
                    state_nx = (skip == 16'd0) ? ST_CAPTURE : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (y_valid) begin
                    skip_inc_c = 1'b1;
                    if (skip_cnt_q + 16'd1 == skip_q) state_nx = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (y_valid) begin
                    wr_en_c = 1'b1;
                    if (wptr_q == len_q - ADDR_WIDTH'(1)) state_nx = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Round-half-up, arithmetic shift, then saturate to the output range
    always_comb begin
        sh_c  = (shift_q > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : shift_q;
        ext_c = $signed({y_in[IN_WIDTH-1], y_in});
        rnd_c = '0;
        if (sh_c != 5'd0) rnd_c = SW'(1) << (sh_c - 5'd1);
        sum_c = ext_c + rnd_c;
        shd_c = sum_c >>> sh_c;
        sat_c = ~((&shd_c[SW-1:OUT_WIDTH-1]) | ~(|shd_c[SW-1:OUT_WIDTH-1]));
        scaled_c = shd_c[OUT_WIDTH-1:0];
        if (sat_c) scaled_c = shd_c[SW-1] ? OUT_MIN : OUT_MAX;
    end

    // Run configuration, counters and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            skip_q     <= '0;
            len_q      <= '0;
            skip_cnt_q <= '0;
            wptr_q     <= '0;
            sat_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (start_c) begin
                shift_q    <= shift;
                skip_q     <= skip;
                len_q      <= (length == '0 || length > DEPTH_A) ? DEPTH_A : length;
                skip_cnt_q <= '0;
                wptr_q     <= '0;
                sat_count  <= '0;
            end else begin
                if (skip_inc_c) skip_cnt_q <= skip_cnt_q + 16'd1;
                if (wr_en_c) begin
                    wptr_q <= wptr_q + ADDR_WIDTH'(1);
                    if (sat_c && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
                end
            end
            busy <= (state_nx == ST_SKIP) || (state_nx == ST_CAPTURE);
            done <= (state_nx == ST_DONE);
        end
    end

    // Buffer contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wptr_q] <= scaled_c;
    end

    // Registered read; a colliding write is seen on the following read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  rd_data <= '0;
        else if (rd_addr >= DEPTH_A) rd_data <= '0;
        else                       rd_data <= mem[rd_addr];
    end

endmodule
